// File: rtl/char_writer.sv
// char_writer: turns a terminal byte stream into writes to the 80x24 circular
// character buffer, tracking the cursor and scrolling by moving the first-char pointer.
module char_writer #(
  parameter int ROWS      = 24,
  parameter int COLS      = 80,
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11,
  parameter int BUF_SIZE  = ROWS * COLS
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ADDR_BITS-1:0] buffer_waddr,
  output logic [7:0]           buffer_din,
  output logic                 buffer_wen,
  output logic [ADDR_BITS-1:0] buffer_first_char,
  output logic                 buffer_first_char_wen,
  output logic [ROW_BITS-1:0]  cursor_row,
  output logic [COL_BITS-1:0]  cursor_col
);

  localparam logic [ADDR_BITS:0]   BUF_SIZE_X = (ADDR_BITS+1)'(BUF_SIZE);
  localparam logic [ADDR_BITS-1:0] COLS_A     = ADDR_BITS'(COLS);
  localparam logic [ADDR_BITS-1:0] ONE_A      = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] INIT_CNT   = ADDR_BITS'(BUF_SIZE - 1);
  localparam logic [ADDR_BITS-1:0] SCROLL_CNT = ADDR_BITS'(COLS - 2);
  localparam logic [ROW_BITS-1:0]  LAST_ROW   = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0]  LAST_COL   = COL_BITS'(COLS - 1);
  localparam logic [7:0]           BLANK      = 8'h20;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_SCROLL} state_t;

  function automatic logic [ADDR_BITS-1:0] addr_add(input logic [ADDR_BITS-1:0] a,
                                                    input logic [ADDR_BITS-1:0] b);
    logic [ADDR_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= BUF_SIZE_X) s = s - BUF_SIZE_X;
    return s[ADDR_BITS-1:0];
  endfunction

  function automatic logic [ADDR_BITS-1:0] addr_sub(input logic [ADDR_BITS-1:0] a,
                                                    input logic [ADDR_BITS-1:0] b);
    logic [ADDR_BITS:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (a < b) s = s + BUF_SIZE_X;
    return s[ADDR_BITS-1:0];
  endfunction

  state_t               state_q, state_d;
  logic                 in_ready_q, in_ready_d;
  logic                 wen_q, wen_d;
  logic [ADDR_BITS-1:0] waddr_q, waddr_d;
  logic [7:0]           din_q, din_d;
  logic [ADDR_BITS-1:0] fc_q, fc_d;
  logic                 fc_wen_q, fc_wen_d;
  logic [ROW_BITS-1:0]  row_q, row_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic [ADDR_BITS-1:0] caddr_q, caddr_d;
  logic [ADDR_BITS-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    din_d      = din_q;
    fc_d       = fc_q;
    fc_wen_d   = 1'b0;
    row_d      = row_q;
    col_d      = col_q;
    caddr_d    = caddr_q;
    clr_ptr_d  = clr_ptr_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_INIT, S_SCROLL: begin
        in_ready_d = 1'b0;
        wen_d      = 1'b1;
        waddr_d    = clr_ptr_q;
        din_d      = BLANK;
        clr_ptr_d  = addr_add(clr_ptr_q, ONE_A);
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - ONE_A;
      end
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            wen_d   = 1'b1;
            waddr_d = caddr_q;
            din_d   = in_data;
            if (col_q != LAST_COL) begin
              col_d   = col_q + COL_BITS'(1);
              caddr_d = addr_add(caddr_q, ONE_A);
            end
          end else if (in_data == 8'h0D) begin
            col_d   = '0;
            caddr_d = addr_sub(caddr_q, ADDR_BITS'(col_q));
          end else if (in_data == 8'h08) begin
            if (col_q != '0) begin
              col_d   = col_q - COL_BITS'(1);
              caddr_d = addr_sub(caddr_q, ONE_A);
            end
          end else if (in_data == 8'h0A) begin
            caddr_d = addr_add(caddr_q, COLS_A);
            if (row_q != LAST_ROW) begin
              row_d = row_q + ROW_BITS'(1);
            end else begin
              // Old first line becomes the new bottom line; its first blank goes out now.
              fc_d       = addr_add(fc_q, COLS_A);
              fc_wen_d   = 1'b1;
              wen_d      = 1'b1;
              waddr_d    = fc_q;
              din_d      = BLANK;
              clr_ptr_d  = addr_add(fc_q, ONE_A);
              cnt_d      = SCROLL_CNT;
              in_ready_d = 1'b0;
              state_d    = S_SCROLL;
            end
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= S_INIT;
      in_ready_q <= 1'b0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      din_q      <= '0;
      fc_q       <= '0;
      fc_wen_q   <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      caddr_q    <= '0;
      clr_ptr_q  <= '0;
      cnt_q      <= INIT_CNT;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      din_q      <= din_d;
      fc_q       <= fc_d;
      fc_wen_q   <= fc_wen_d;
      row_q      <= row_d;
      col_q      <= col_d;
      caddr_q    <= caddr_d;
      clr_ptr_q  <= clr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready              = in_ready_q;
  assign buffer_wen            = wen_q;
  assign buffer_waddr          = waddr_q;
  assign buffer_din            = din_q;
  assign buffer_first_char     = fc_q;
  assign buffer_first_char_wen = fc_wen_q;
  assign cursor_row            = row_q;
  assign cursor_col            = col_q;

endmodule

// File: tb/tb_char_writer.sv
// Bench for char_writer: vector table, scroll/reset sequences and random bytes
// checked against a screen-level model of the circular buffer.
module tb_char_writer;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] buffer_waddr;
  logic [7:0]  buffer_din;
  logic        buffer_wen;
  logic [10:0] buffer_first_char;
  logic        buffer_first_char_wen;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;

  char_writer dut (
    .clk(clk), .clr(clr), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .buffer_waddr(buffer_waddr), .buffer_din(buffer_din), .buffer_wen(buffer_wen),
    .buffer_first_char(buffer_first_char), .buffer_first_char_wen(buffer_first_char_wen),
    .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model of the screen: buffer contents, cursor and first-char pointer.
  logic [7:0] mdl_mem [1920];
  int mrow, mcol, mfc;

  // What the DUT has written into the buffer.
  logic [7:0] mirror [1920];
  bit oob = 1'b0;
  always @(posedge clk) begin
    if (buffer_wen) begin
      if (int'(buffer_waddr) < 1920) mirror[int'(buffer_waddr)] <= buffer_din;
      else oob <= 1'b1;
    end
  end

  int last_scroll_first, last_scroll_last;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 1920; i++) mdl_mem[i] = 8'h20;
    mrow = 0; mcol = 0; mfc = 0;
  endfunction

  function automatic void model_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      mdl_mem[(mfc + mrow * 80 + mcol) % 1920] = b;
      if (mcol < 79) mcol++;
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (b == 8'h0A) begin
      if (mrow < 23) mrow++;
      else begin
        for (int i = 0; i < 80; i++) mdl_mem[(mfc + i) % 1920] = 8'h20;
        mfc = (mfc + 80) % 1920;
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 400 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_apply(b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wen", buffer_wen, 0);
    chk("rst_waddr", buffer_waddr, 0);
    chk("rst_din", buffer_din, 0);
    chk("rst_first_char", buffer_first_char, 0);
    chk("rst_fc_wen", buffer_first_char_wen, 0);
    chk("rst_row", cursor_row, 0);
    chk("rst_col", cursor_col, 0);
  endtask

  // Called at a negedge with clr high.
  task automatic run_init();
    int nw, errs, gaps, i;
    nw = 0; errs = 0; gaps = 0;
    check_reset_vals();
    clr = 1'b0;
    for (i = 1; i <= 2100; i++) begin
      @(negedge clk);
      if (in_ready) break;
      if (buffer_wen) begin
        if (int'(buffer_waddr) != nw || buffer_din != 8'h20) errs++;
        nw++;
      end else if (nw < 1920) gaps++;
    end
    chk("init_writes", nw, 1920);
    chk("init_addr_data", errs, 0);
    chk("init_gaps", gaps, 0);
    chk("init_ready_cycle", i, 1921);
    chk("init_row", cursor_row, 0);
    chk("init_col", cursor_col, 0);
    model_reset();
  endtask

  // Scrolling LF from row 23 with full timing check; optionally pokes bytes while busy.
  task automatic do_scroll(input bit poke);
    int oldfc, errs, r0, c0;
    oldfc = mfc; r0 = mrow; c0 = mcol; errs = 0;
    send_byte(8'h0A);
    chk("scroll_fc_wen", buffer_first_char_wen, 1);
    chk("scroll_first_char", buffer_first_char, (oldfc + 80) % 1920);
    chk("scroll_ready_low", in_ready, 0);
    chk("scroll_wen_c1", buffer_wen, 1);
    chk("scroll_waddr_c1", buffer_waddr, oldfc);
    last_scroll_first = buffer_waddr;
    if (poke) begin
      in_data = 8'h5A;
      in_valid = 1'b1;
    end
    for (int k = 2; k <= 80; k++) begin
      @(negedge clk);
      if (in_ready || !buffer_wen || buffer_first_char_wen) errs++;
      if (int'(buffer_waddr) != (oldfc + k - 1) % 1920 || buffer_din != 8'h20) errs++;
    end
    last_scroll_last = buffer_waddr;
    in_valid = 1'b0;
    chk("scroll_clear_seq", errs, 0);
    @(negedge clk);
    chk("scroll_ready_back", in_ready, 1);
    chk("scroll_wen_off", buffer_wen, 0);
    chk("scroll_row", cursor_row, r0);
    chk("scroll_col", cursor_col, c0);
  endtask

  typedef struct {
    logic [7:0] b;
    int         row;
    int         col;
    logic       wen;
    int         waddr;
    logic [7:0] din;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int nmis, n;
    logic [7:0] b;
    int r;

    vecs[0]  = '{8'h41, 0, 1, 1'b1, 0,  8'h41};
    vecs[1]  = '{8'h42, 0, 2, 1'b1, 1,  8'h42};
    vecs[2]  = '{8'h08, 0, 1, 1'b0, 0,  8'h00};
    vecs[3]  = '{8'h43, 0, 2, 1'b1, 1,  8'h43};
    vecs[4]  = '{8'h0D, 0, 0, 1'b0, 0,  8'h00};
    vecs[5]  = '{8'h0A, 1, 0, 1'b0, 0,  8'h00};
    vecs[6]  = '{8'h44, 1, 1, 1'b1, 80, 8'h44};
    vecs[7]  = '{8'h07, 1, 1, 1'b0, 0,  8'h00};
    vecs[8]  = '{8'h7F, 1, 1, 1'b0, 0,  8'h00};
    vecs[9]  = '{8'h7E, 1, 2, 1'b1, 81, 8'h7E};
    vecs[10] = '{8'h08, 1, 1, 1'b0, 0,  8'h00};
    vecs[11] = '{8'h08, 1, 0, 1'b0, 0,  8'h00};
    vecs[12] = '{8'h08, 1, 0, 1'b0, 0,  8'h00};
    vecs[13] = '{8'h1F, 1, 0, 1'b0, 0,  8'h00};
    vecs[14] = '{8'h20, 1, 1, 1'b1, 80, 8'h20};
    vecs[15] = '{8'h0D, 1, 0, 1'b0, 0,  8'h00};

    model_reset();
    repeat (3) @(negedge clk);
    run_init();

    // Back-to-back table: each byte is accepted on consecutive edges.
    for (int i = 0; i < 16; i++) begin
      send_byte(vecs[i].b);
      chk("vec_row", cursor_row, vecs[i].row);
      chk("vec_col", cursor_col, vecs[i].col);
      chk("vec_wen", buffer_wen, vecs[i].wen);
      chk("vec_ready", in_ready, 1);
      if (vecs[i].wen) begin
        chk("vec_waddr", buffer_waddr, vecs[i].waddr);
        chk("vec_din", buffer_din, vecs[i].din);
      end
    end

    // No autowrap: 82 chars on row 2, last three land on column 79.
    send_byte(8'h0A);
    for (int i = 1; i <= 82; i++) begin
      send_byte(8'h78);
      if (i >= 80) chk("nowrap_waddr", buffer_waddr, 239);
    end
    chk("nowrap_col", cursor_col, 79);
    send_byte(8'h08);
    chk("bs_col", cursor_col, 78);
    send_byte(8'h0D);
    chk("cr_col", cursor_col, 0);
    repeat (21) send_byte(8'h0A);
    chk("lf_row23", cursor_row, 23);

    // A full lap of scrolls brings the first-char pointer back to 0.
    for (int i = 0; i < 24; i++) do_scroll(i == 0);
    chk("lap_first_char", buffer_first_char, 0);
    chk("lap_clear_first", last_scroll_first, 1840);
    chk("lap_clear_last", last_scroll_last, 1919);
    chk("lap_row", cursor_row, 23);
    chk("lap_col", cursor_col, 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      b = 8'($urandom_range(32, 126));
      else if (r < 70) b = 8'h0D;
      else if (r < 82) b = 8'h0A;
      else if (r < 90) b = 8'h08;
      else if (r < 95) b = 8'($urandom_range(0, 31));
      else             b = 8'($urandom_range(127, 255));
      send_byte(b);
      chk("rand_row", cursor_row, mrow);
      chk("rand_col", cursor_col, mcol);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rand_settle", in_ready, 1);
    chk("rand_first_char", buffer_first_char, mfc);
    nmis = 0;
    for (int i = 0; i < 1920; i++) if (mirror[i] !== mdl_mem[i]) nmis++;
    chk("rand_mem_cells", nmis, 0);
    chk("addr_in_range", oob, 0);

    // Reset in the middle of a scroll clear aborts it and reruns INIT.
    while (mrow < 23) send_byte(8'h0A);
    send_byte(8'h0A);
    repeat (39) @(negedge clk);
    chk("midscroll_wen", buffer_wen, 1);
    #2 clr = 1'b1;
    #1 check_reset_vals();
    @(negedge clk);
    run_init();
    send_byte(8'h41);
    chk("post_rst_waddr", buffer_waddr, 0);
    chk("post_rst_col", cursor_col, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
